// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: main sequencing FSM plus ALU and immediate
// decoders. Covers lw, sw, R-type, I-type ALU, beq and jal.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   FETCH    0 | read instruction at PC, PC <= PC + 4
//   DECODE   1 | read registers, precompute branch target oldPC + imm
//   MEMADR   2 | rs1 + imm address calculation for lw/sw
//   MEMREAD  3 | read data memory at computed address
//   MEMWB    4 | write loaded data into rd
//   MEMWRITE 5 | write rs2 into data memory
//   EXECUTER 6 | R-type ALU operation rs1 op rs2
//   ALUWB    7 | write ALU result register into rd
//   EXECUTEI 8 | I-type ALU operation rs1 op imm
//   JAL      9 | PC <= branch target, compute return address oldPC + 4
//   BEQ     10 | compare rs1 - rs2, PC <= target when equal
module multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               zero,
    output logic               pcwrite,
    output logic               adrsrc,
    output logic               memwrite,
    output logic               irwrite,
    output logic [1:0]         resultsrc,
    output logic [1:0]         alusrca,
    output logic [1:0]         alusrcb,
    output logic               regwrite,
    output logic [1:0]         immsrc,
    output logic [2:0]         alucontrol,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = STATE_W'(0),
        S_DECODE   = STATE_W'(1),
        S_MEMADR   = STATE_W'(2),
        S_MEMREAD  = STATE_W'(3),
        S_MEMWB    = STATE_W'(4),
        S_MEMWRITE = STATE_W'(5),
        S_EXECUTER = STATE_W'(6),
        S_ALUWB    = STATE_W'(7),
        S_EXECUTEI = STATE_W'(8),
        S_JAL      = STATE_W'(9),
        S_BEQ      = STATE_W'(10)
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t     state_q;
    state_t     state_n;
    logic       pcupdate;
    logic       branch;
    logic       memwrite_i;
    logic       irwrite_i;
    logic       regwrite_i;
    logic       illegal_i;
    logic [1:0] aluop;

    // State register; reset may land from any state, including mid-instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state and Moore control outputs; unused codes fall back to FETCH.
    always_comb begin
        state_n    = S_FETCH;
        pcupdate   = 1'b0;
        branch     = 1'b0;
        adrsrc     = 1'b0;
        memwrite_i = 1'b0;
        irwrite_i  = 1'b0;
        regwrite_i = 1'b0;
        illegal_i  = 1'b0;
        resultsrc  = 2'b00;
        alusrca    = 2'b00;
        alusrcb    = 2'b00;
        aluop      = 2'b00;
        case (state_q)
            S_FETCH: begin
                irwrite_i = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                pcupdate  = 1'b1;
                state_n   = S_DECODE;
            end
            S_DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
                case (op)
                    OP_LOAD,
                    OP_STORE:  state_n = S_MEMADR;
                    OP_RTYPE:  state_n = S_EXECUTER;
                    OP_ITYPE:  state_n = S_EXECUTEI;
                    OP_JAL:    state_n = S_JAL;
                    OP_BRANCH: state_n = S_BEQ;
                    default: begin
                        state_n   = S_FETCH;
                        illegal_i = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                state_n = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adrsrc  = 1'b1;
                state_n = S_MEMWB;
            end
            S_MEMWB: begin
                resultsrc  = 2'b01;
                regwrite_i = 1'b1;
            end
            S_MEMWRITE: begin
                adrsrc     = 1'b1;
                memwrite_i = 1'b1;
            end
            S_EXECUTER: begin
                alusrca = 2'b10;
                aluop   = 2'b10;
                state_n = S_ALUWB;
            end
            S_EXECUTEI: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                aluop   = 2'b10;
                state_n = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite_i = 1'b1;
            end
            S_BEQ: begin
                alusrca = 2'b10;
                aluop   = 2'b01;
                branch  = 1'b1;
            end
            S_JAL: begin
                alusrca  = 2'b01;
                alusrcb  = 2'b10;
                pcupdate = 1'b1;
                state_n  = S_ALUWB;
            end
            default: begin
                state_n = S_FETCH;
            end
        endcase
    end

    // ALU decoder; only R-type (op[5]=1) with funct7b5 turns add into sub.
    always_comb begin
        alucontrol = 3'b000;
        case (aluop)
            2'b00: alucontrol = 3'b000;
            2'b01: alucontrol = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  alucontrol = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alucontrol = 3'b101;
                    3'b110:  alucontrol = 3'b011;
                    3'b111:  alucontrol = 3'b010;
                    default: alucontrol = 3'b000;
                endcase
            end
            default: alucontrol = 3'b000;
        endcase
    end

    // Immediate format selected straight from the opcode.
    always_comb begin
        immsrc = 2'b00;
        case (op)
            OP_STORE:  immsrc = 2'b01;
            OP_BRANCH: immsrc = 2'b10;
            OP_JAL:    immsrc = 2'b11;
            default:   immsrc = 2'b00;
        endcase
    end

    // Architectural enables are suppressed for the whole reset cycle.
    assign pcwrite    = ~reset & (pcupdate | (branch & zero));
    assign memwrite   = ~reset & memwrite_i;
    assign irwrite    = ~reset & irwrite_i;
    assign regwrite   = ~reset & regwrite_i;
    assign illegal_op = ~reset & illegal_i;
    assign state      = state_q;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Control FSM and ALU decoder for the multicycle RV32I datapath (lw, sw, R-type, I-type ALU, beq, jal). It decodes op/funct fields from the instruction register and sequences datapath control over several cycles. It drives alucontrol into the ALU using the ALU encoding: 000 add, 001 sub, 010 and, 011 or, 101 slt. It consumes the ALU zero flag to resolve branches.

Parameters:
STATE_W, 4, width of state register and debug state output

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
op  input  7  instr[6:0], held stable by instruction register after FETCH
funct3  input  3  instr[14:12]
funct7b5  input  1  instr[30]
zero  input  1  ALU zero flag
pcwrite  output  1  PC register enable
adrsrc  output  1  memory address select: 0=PC, 1=ALU result register
memwrite  output  1  data memory write enable
irwrite  output  1  instruction register / oldPC enable
resultsrc  output  2  result mux: 00 ALUOut, 01 Data, 10 ALUResult
alusrca  output  2  SrcA mux: 00 PC, 01 oldPC, 10 rs1 data
alusrcb  output  2  SrcB mux: 00 rs2 data, 01 immext, 10 constant 4
regwrite  output  1  register file write enable
immsrc  output  2  immediate format: 00 I, 01 S, 10 B, 11 J
alucontrol  output  3  ALU operation select
illegal_op  output  1  unsupported opcode seen in DECODE
state  output  STATE_W  current state, debug/verification

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. A reset sampled high at a rising edge loads state FETCH (0). This applies from any state, including mid-instruction.
- While reset is high, pcwrite, memwrite, regwrite and irwrite are forced to 0 combinationally.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10. Codes 11-15 go to FETCH on the next edge, with all enables 0.
- Moore outputs per state. Any output not listed is 0; internal aluop defaults to 00.
  - FETCH: adrsrc=0, irwrite=1, alusrca=00, alusrcb=10, aluop=00, resultsrc=10, pcupdate=1.
  - DECODE: alusrca=01, alusrcb=01, aluop=00 (branch target precompute).
  - MEMADR: alusrca=10, alusrcb=01, aluop=00.
  - MEMREAD: resultsrc=00, adrsrc=1.
  - MEMWB: resultsrc=01, regwrite=1.
  - MEMWRITE: resultsrc=00, adrsrc=1, memwrite=1.
  - EXECUTER: alusrca=10, alusrcb=00, aluop=10.
  - EXECUTEI: alusrca=10, alusrcb=01, aluop=10.
  - ALUWB: resultsrc=00, regwrite=1.
  - BEQ: alusrca=10, alusrcb=00, aluop=01, resultsrc=00, branch=1.
  - JAL: alusrca=01, alusrcb=10, aluop=00, resultsrc=00, pcupdate=1.
- pcwrite = pcupdate | (branch & zero), combinational. zero is sampled in the BEQ cycle only.
- Transitions:
  - FETCH -> DECODE.
  - DECODE, by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1101111 -> JAL; 1100011 -> BEQ.
  - DECODE, any other op -> FETCH, with illegal_op=1 for that DECODE cycle only.
  - MEMADR: op[5]=0 -> MEMREAD, op[5]=1 -> MEMWRITE.
  - MEMREAD -> MEMWB -> FETCH. MEMWRITE -> FETCH.
  - EXECUTER and EXECUTEI -> ALUWB -> FETCH.
  - JAL -> ALUWB. BEQ -> FETCH.
- Cycles per instruction: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3, illegal 2.
- ALU decode (combinational):
  - aluop 00 -> 000; aluop 01 -> 001.
  - aluop 10, by funct3: 000 -> 001 if (op[5] & funct7b5), else 000; 010 -> 101; 110 -> 011; 111 -> 010; any other funct3 -> 000.
  - aluop 11 -> 000.
  - I-type addi never subtracts, because op[5]=0.
- immsrc (combinational from op): 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, else 00.
- illegal_op reset value is 0. All enables reset to 0 and reach FETCH values one edge after reset deasserts.

Test Plan:
- Reset then lw (op=0000011): release reset -> state sequence 0,1,2,3,4,0; irwrite=1 only in cycle 0; regwrite=1 with resultsrc=01 in state 4; memwrite never 1.
- sw (op=0100011): state sequence 0,1,2,5,0; memwrite=1 and adrsrc=1 in state 5; immsrc=01; regwrite stays 0.
- R-type sub (op=0110011, funct3=000, funct7b5=1) -> alucontrol=001 in EXECUTER. Same with funct7b5=0 -> 000. funct3=010 -> 101; funct3=110 -> 011; funct3=111 -> 010. addi with funct7b5=1 -> 000.
- beq (op=1100011): zero=1 in BEQ -> pcwrite=1 with alucontrol=001, then FETCH. zero=0 -> pcwrite=0. Sequence 0,1,10,0.
- jal (op=1101111): sequence 0,1,9,7,0; pcwrite=1 in JAL; regwrite=1 in ALUWB; immsrc=11.
- op=0000000 -> illegal_op=1 in DECODE, then FETCH. Separately: assert reset during MEMWRITE -> memwrite=0 that cycle; state=0 after the edge.
